// File: rtl/acc_fwd_rx.sv
// Receive end of the CPU forwarding port: tags each forwarded word with its
// position in the band (pivot row / pivot column / element) and queues it.
module acc_fwd_rx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int MAX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [3:0]        cfg_piv_len,
  input  logic [7:0]        cfg_rows,
  input  logic [3:0]        cfg_row_len,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic              fwd_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_kind,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              almost_full,
  output logic              err_overflow,
  output logic              err_unexpected,
  output logic              band_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 6;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ALMST = (AW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, PIVROW, PIVCOL, ROWELEM} state_t;

  function automatic logic [3:0] sat_len(input logic [3:0] len);
    sat_len = (len > 4'(MAX_W)) ? 4'(MAX_W) : len;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  piv_len_q, row_len_q, cnt, cnt_nxt;
  logic [7:0]  rows_q, rows_nxt;
  logic [1:0]  kind_in;
  logic [2:0]  idx_in;
  logic        last_in;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          word_in, full, pop, push;

  // Ingress classification: tag of the current word and where framing goes next
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rows_nxt  = rows_q;
    kind_in   = 2'd0;
    idx_in    = cnt[2:0];
    last_in   = 1'b0;
    case (state)
      PIVROW: begin
        kind_in = 2'd0;
        if (cnt == piv_len_q - 4'd1) begin
          cnt_nxt = '0;
          if (rows_q == 8'd0) begin
            last_in   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = PIVCOL;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      PIVCOL: begin
        kind_in = 2'd1;
        idx_in  = 3'd0;
        cnt_nxt = '0;
        if (row_len_q == 4'd0) begin
          // Empty row: the pivot-column word alone completes it
          rows_nxt = rows_q - 8'd1;
          if (rows_q == 8'd1) begin
            last_in   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = PIVCOL;
          end
        end else begin
          state_nxt = ROWELEM;
        end
      end
      ROWELEM: begin
        kind_in = 2'd2;
        if (cnt == row_len_q - 4'd1) begin
          cnt_nxt  = '0;
          rows_nxt = rows_q - 8'd1;
          if (rows_q == 8'd1) begin
            last_in   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = PIVCOL;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rows_q    <= '0;
      piv_len_q <= '0;
      row_len_q <= '0;
    end else if (state == IDLE) begin
      if (cfg_start) begin
        state     <= PIVROW;
        cnt       <= '0;
        piv_len_q <= sat_len(cfg_piv_len);
        rows_q    <= cfg_rows;
        row_len_q <= sat_len(cfg_row_len);
      end
    end else if (fwd_valid) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rows_q <= rows_nxt;
    end
  end

  assign word_in   = fwd_valid && (state != IDLE);
  assign full      = (count == CNT_FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = word_in && (!full || pop);

  // FIFO storage; a dropped word still advanced the framing above
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {fwd_data, kind_in, idx_in, last_in};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (word_in && !push)                 err_overflow   <= 1'b1;
      if (fwd_valid && (state == IDLE))     err_unexpected <= 1'b1;
    end
  end

  assign {out_data, out_kind, out_idx, out_last} = mem[rd_ptr];
  assign busy        = (state != IDLE);
  assign almost_full = (count >= CNT_ALMST);
  assign band_done   = push && last_in;

endmodule

// File: tb/tb_acc_fwd_rx.sv
// Directed bench for acc_fwd_rx: vector table for the nominal band plus
// hand-written sequences for backpressure, overflow, reset and framing corners.
module tb_acc_fwd_rx;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cfg_start = 1'b0;
  logic [3:0]        cfg_piv_len = '0;
  logic [7:0]        cfg_rows = '0;
  logic [3:0]        cfg_row_len = '0;
  logic [DATA_W-1:0] fwd_data = '0;
  logic              fwd_valid = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_kind;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy, almost_full, err_overflow, err_unexpected, band_done;

  always #5 clk = ~clk;

  acc_fwd_rx #(.DATA_W(DATA_W), .DEPTH(8), .MAX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_piv_len(cfg_piv_len),
    .cfg_rows(cfg_rows), .cfg_row_len(cfg_row_len), .fwd_data(fwd_data),
    .fwd_valid(fwd_valid), .out_data(out_data), .out_kind(out_kind),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .almost_full(almost_full),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected),
    .band_done(band_done)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  kind;
    logic [2:0]  idx;
    logic        last;
  } vec_t;

  vec_t nom [16];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; cfg_start = 1'b0; fwd_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  // Entered and left at posedge+1
  task automatic start_band(input logic [3:0] pl, input logic [7:0] rw, input logic [3:0] rl);
    cfg_start = 1'b1; cfg_piv_len = pl; cfg_rows = rw; cfg_row_len = rl;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  initial begin
    nom[0]  = '{32'hA000_0000, 2'd0, 3'd0, 1'b0};
    nom[1]  = '{32'hA000_0001, 2'd0, 3'd1, 1'b0};
    nom[2]  = '{32'hA000_0002, 2'd0, 3'd2, 1'b0};
    nom[3]  = '{32'hA000_0003, 2'd0, 3'd3, 1'b0};
    nom[4]  = '{32'hB000_0004, 2'd1, 3'd0, 1'b0};
    nom[5]  = '{32'hC000_0005, 2'd2, 3'd0, 1'b0};
    nom[6]  = '{32'hC000_0006, 2'd2, 3'd1, 1'b0};
    nom[7]  = '{32'hC000_0007, 2'd2, 3'd2, 1'b0};
    nom[8]  = '{32'hB000_0008, 2'd1, 3'd0, 1'b0};
    nom[9]  = '{32'hC000_0009, 2'd2, 3'd0, 1'b0};
    nom[10] = '{32'hC000_000A, 2'd2, 3'd1, 1'b0};
    nom[11] = '{32'hC000_000B, 2'd2, 3'd2, 1'b0};
    nom[12] = '{32'hB000_000C, 2'd1, 3'd0, 1'b0};
    nom[13] = '{32'hC000_000D, 2'd2, 3'd0, 1'b0};
    nom[14] = '{32'hC000_000E, 2'd2, 3'd1, 1'b0};
    nom[15] = '{32'hC000_000F, 2'd2, 3'd2, 1'b1};

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_kind", out_kind, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_band_done", band_done, 0);
    chk("rst_err_ovf", err_overflow, 0);
    chk("rst_err_unexp", err_unexpected, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Nominal band, consumer always ready
    start_band(4'd4, 8'd3, 4'd3);
    chk("nom_busy_start", busy, 1);
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        fwd_valid = 1'b1; fwd_data = nom[i].data;
      end else begin
        fwd_valid = 1'b0;
      end
      #1 chk($sformatf("nom_band_done_%0d", i), band_done, (i == 15));
      @(posedge clk); #1;
      if (i < 16) begin
        chk($sformatf("nom_valid_%0d", i), out_valid, 1);
        chk($sformatf("nom_data_%0d", i), out_data, nom[i].data);
        chk($sformatf("nom_kind_%0d", i), out_kind, nom[i].kind);
        chk($sformatf("nom_idx_%0d", i), out_idx, nom[i].idx);
        chk($sformatf("nom_last_%0d", i), out_last, nom[i].last);
        chk($sformatf("nom_busy_%0d", i), busy, (i < 15));
      end
    end
    chk("nom_drained", out_valid, 0);
    chk("nom_no_ovf", err_overflow, 0);
    chk("nom_no_unexp", err_unexpected, 0);

    // rows=0: two pivot-row words, second is last; cfg_start while busy ignored
    start_band(4'd2, 8'd0, 4'd5);
    fwd_valid = 1'b1; fwd_data = 32'h0000_0011;
    cfg_start = 1'b1; cfg_piv_len = 4'd5; cfg_rows = 8'd4;
    #1 chk("r0_band_done_w1", band_done, 0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("r0_w1_kind", out_kind, 0);
    chk("r0_w1_idx", out_idx, 0);
    chk("r0_w1_last", out_last, 0);
    chk("r0_busy_mid", busy, 1);
    fwd_data = 32'h0000_0022;
    #1 chk("r0_band_done_w2", band_done, 1);
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    chk("r0_w2_data", out_data, 32'h0000_0022);
    chk("r0_w2_idx", out_idx, 1);
    chk("r0_w2_last", out_last, 1);
    chk("r0_busy_end", busy, 0);

    // Backpressure and overflow, then framing continues past dropped words
    do_reset();
    start_band(4'd8, 8'd1, 4'd8);
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      fwd_valid = 1'b1; fwd_data = 32'(i);
      @(posedge clk); #1;
      if (i == 5) chk("ovf_af_at5", almost_full, 0);
      if (i == 6) chk("ovf_af_at6", almost_full, 1);
      if (i == 8) chk("ovf_no_err_at8", err_overflow, 0);
    end
    fwd_valid = 1'b0;
    chk("ovf_err", err_overflow, 1);
    chk("ovf_head_held", out_data, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_drain_valid_%0d", k), out_valid, 1);
      chk($sformatf("ovf_drain_data_%0d", k), out_data, 32'(k));
      chk($sformatf("ovf_drain_idx_%0d", k), out_idx, 32'(k - 1));
      @(posedge clk); #1;
    end
    chk("ovf_empty", out_valid, 0);
    fwd_valid = 1'b1; fwd_data = 32'h0000_000B;
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    chk("ovf_frame_kind", out_kind, 2);
    chk("ovf_frame_idx", out_idx, 1);
    chk("ovf_frame_data", out_data, 32'h0000_000B);
    chk("ovf_err_sticky", err_overflow, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    start_band(4'd8, 8'd1, 4'd8);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      fwd_valid = 1'b1; fwd_data = 32'h100 + 32'(i);
      @(posedge clk); #1;
    end
    chk("pp_af_full", almost_full, 1);
    fwd_data = 32'h109; out_ready = 1'b1;
    @(posedge clk); #1;
    fwd_valid = 1'b0; out_ready = 1'b0;
    chk("pp_no_ovf", err_overflow, 0);
    chk("pp_head", out_data, 32'h102);
    fwd_valid = 1'b1; fwd_data = 32'h10A;
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    chk("pp_still_full", err_overflow, 1);
    out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("pp_drain_%0d", k), out_data, 32'h100 + 32'(k));
      @(posedge clk); #1;
    end
    chk("pp_empty", out_valid, 0);

    // fwd_valid while idle
    do_reset();
    fwd_valid = 1'b1; fwd_data = 32'h4150_0000;
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    chk("unexp_err", err_unexpected, 1);
    chk("unexp_out_valid", out_valid, 0);
    chk("unexp_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 chk("unexp_sticky", err_unexpected, 1);

    // Reset in the middle of a band
    do_reset();
    start_band(4'd4, 8'd3, 4'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fwd_valid = 1'b1; fwd_data = nom[i].data;
      @(posedge clk); #1;
    end
    fwd_valid = 1'b0;
    chk("mid_valid_before", out_valid, 1);
    chk("mid_busy_before", busy, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("mid_valid_async", out_valid, 0);
    chk("mid_busy_async", busy, 0);
    chk("mid_data_async", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mid_no_stale", out_valid, 0);
    fwd_valid = 1'b1; fwd_data = nom[5].data;
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    chk("mid_unexp_after", err_unexpected, 1);
    chk("mid_valid_after", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_fwd_rx.md
ACC_FWD_RX -- requirements
Module: acc_fwd_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, forwarded word width.
- DEPTH, 8, FIFO entries (power of two).
- MAX_W, 8, maximum band width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst_n, in, 1, reset (asynchronous, active-high).
- cfg_start, in, 1, one-cycle band start pulse.
- cfg_piv_len, in, 4, pivot-row words per band (1..MAX_W).
- cfg_rows, in, 8, non-pivot rows per band (0..255).
- cfg_row_len, in, 4, element words per non-pivot row (0..MAX_W).
- fwd_data, in, DATA_W, forwarded load data from the CPU writeback stage.
- fwd_valid, in, 1, fwd_data valid (no backpressure).
- out_data, out, DATA_W, head word.
- out_kind, out, 2, tag: 0 PIVROW, 1 PIVCOL, 2 ELEM.
- out_idx, out, 3, lane index within the row.
- out_last, out, 1, last word of the band.
- out_valid, out, 1, head valid.
- out_ready, in, 1, consumer accept.
- busy, out, 1, band in progress.
- almost_full, out, 1, free entries <= 2.
- err_overflow, out, 1, sticky FIFO overflow.
- err_unexpected, out, 1, sticky fwd_valid while IDLE.
- band_done, out, 1, one-cycle pulse when the last band word is enqueued.

Function
REQ-003 The block SHALL be the receive end of the CPU forwarding port: it classifies each fwd_valid word at ingress and stores {data, kind, idx, last} in the FIFO.
REQ-004 The FSM SHALL have the states IDLE, PIVROW, PIVCOL, ROWELEM.
REQ-005 IDLE SHALL move to PIVROW on cfg_start; cfg_piv_len, cfg_rows and cfg_row_len SHALL be latched that cycle.
REQ-006 PIVROW SHALL tag words PIVROW with idx 0..piv_len-1; after word piv_len-1 it SHALL go to PIVCOL, or to IDLE if rows=0.
REQ-007 PIVCOL SHALL tag one word PIVCOL, idx 0, then go to ROWELEM, or go to PIVCOL again if row_len=0 and rows remain.
REQ-008 ROWELEM SHALL tag words ELEM with idx 0..row_len-1; after the last word it SHALL decrement the row counter and go to PIVCOL, or to IDLE when no rows remain.
REQ-009 The final band word SHALL carry last=1, and band_done SHALL pulse in the same cycle that word is enqueued.
REQ-010 State and counters SHALL advance only on cycles where fwd_valid=1.
REQ-011 A word SHALL be enqueued if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-012 Otherwise the word SHALL be dropped, err_overflow SHALL be set, and the tag counters SHALL still advance so that framing is preserved.
REQ-013 fwd_valid in IDLE SHALL set err_unexpected; the word SHALL be dropped.
REQ-014 cfg_start while busy SHALL be ignored.
REQ-015 busy SHALL equal (state != IDLE).
REQ-016 A word sampled at clock edge t SHALL appear on out_* at edge t+1 when the FIFO was empty; there is no combinational fwd->out path.
REQ-017 A pop SHALL occur when out_valid and out_ready are both 1; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 Simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a log2(DEPTH)+1-bit counter.
REQ-020 Error flags SHALL clear only on reset.

Reset
REQ-021 While rst_n=1, the block SHALL asynchronously reset to:
- state=IDLE;
- FIFO empty, pointers 0;
- out_valid=0, out_data=0, out_kind=0, out_idx=0, out_last=0;
- busy=0, almost_full=0, band_done=0;
- both error flags 0.
REQ-022 A reset asserted mid-band SHALL discard all buffered words and the band.
REQ-023 After reset deassertion, fwd_valid SHALL be treated as unexpected until cfg_start is seen.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Nominal band: piv_len=4, rows=3, row_len=3, 16 consecutive words, out_ready=1 -> kinds 0,0,0,0,1,2,2,2,1,2,2,2,1,2,2,2; idx resets per row; last=1 only on word 16; band_done pulses once; busy falls the cycle after word 16.
- Backpressure and overflow: out_ready=0, 10 words into DEPTH=8 -> almost_full at 6 entries; words 9 and 10 dropped; err_overflow=1; the 8 stored words drain in order once out_ready=1.
- Full FIFO with simultaneous push and pop -> occupancy stays 8; no overflow.
- fwd_valid=1 in IDLE with data 0x41500000 -> err_unexpected=1; out_valid stays 0.
- rows=0, piv_len=2 -> 2 PIVROW words, the second with last=1; return to IDLE.
- Reset asserted after 5 words of the nominal band -> out_valid=0 and busy=0 immediately; no stale word after release.
